// File: rtl/neuron_learn_layer_seq_pkg.sv
// Shared types, fixed-point constants, FSM states and saturation helpers for the learning layer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// zero2one_t: unsigned activations, ZERO2ONE_ONE represents 1.0.
// frac_t:     signed weights and pre-activations, saturating arithmetic via sat_frac().
package neuron_learn_layer_seq_pkg;

  localparam int ZW            = 8;
  localparam int FW            = 16;
  localparam int ZERO2ONE_FRAC = 7;
  localparam int FRAC_FRAC     = 7;
  localparam int WIDE_W        = 48;

  typedef logic [ZW-1:0]            zero2one_t;
  typedef logic signed [FW-1:0]     frac_t;
  typedef logic signed [WIDE_W-1:0] wide_t;

  localparam zero2one_t ZERO2ONE_ONE = zero2one_t'(1 << ZERO2ONE_FRAC);
  localparam frac_t     FRAC_MAX     = frac_t'({1'b0, {(FW-1){1'b1}}});
  localparam frac_t     FRAC_MIN     = frac_t'({1'b1, {(FW-1){1'b0}}});

  typedef enum logic [2:0] {IDLE, FWD, LRN, AVG, DONE} layer_state_e;

  function automatic wide_t to_wide_z(input zero2one_t z);
    return wide_t'({1'b0, z});
  endfunction

  function automatic wide_t to_wide_f(input frac_t f);
    return wide_t'(f);
  endfunction

  // Clamp a wide intermediate into frac_t range instead of wrapping.
  function automatic frac_t sat_frac(input wide_t x);
    if (x > to_wide_f(FRAC_MAX)) return FRAC_MAX;
    else if (x < to_wide_f(FRAC_MIN)) return FRAC_MIN;
    else return frac_t'(x[FW-1:0]);
  endfunction

  // Pre-activation to output: clamp to [0, 1.0] then move to zero2one scaling.
  function automatic zero2one_t to_zero2one(input frac_t a);
    if (a < 0) return '0;
    else if (a > frac_t'(ZERO2ONE_ONE)) return ZERO2ONE_ONE;
    else return zero2one_t'(a >>> (FRAC_FRAC - ZERO2ONE_FRAC));
  endfunction

  // Per-input back-propagated target: in + e*w_old, clamped to [0, 1.0].
  function automatic zero2one_t back_target(input zero2one_t x, input wide_t e_w, input frac_t w_old);
    wide_t v;
    v = to_wide_z(x) + ((e_w * to_wide_f(w_old)) >>> FRAC_FRAC);
    if (v < 0) return '0;
    else if (v > to_wide_z(ZERO2ONE_ONE)) return ZERO2ONE_ONE;
    else return zero2one_t'(v[ZW-1:0]);
  endfunction

endpackage

// File: rtl/neuron_mac_row.sv
// Combinational N-wide dot product of one weight row with the input vector, saturated to frac_t.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; evaluated every cycle.
//
// Ports: w - one neuron's weight row (frac_t), x - input activations (zero2one_t),
//        a - sat_frac(sum w*x >>> ZERO2ONE_FRAC).
module neuron_mac_row
  import neuron_learn_layer_seq_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0][FW-1:0] w,
  input  logic [N-1:0][ZW-1:0] x,
  output logic [FW-1:0]        a
);

  wide_t sum;

  always_comb begin
    sum = '0;
    for (int i = 0; i < N; i++) begin
      sum = sum + to_wide_f(frac_t'(w[i])) * to_wide_z(x[i]);
    end
    a = sat_frac(sum >>> ZERO2ONE_FRAC);
  end

endmodule

// File: rtl/neuron_learn_layer_seq.sv
// Time-multiplexed learning layer: M neurons share one N-wide MAC row, one neuron per cycle.
// Latency: accept at edge k -> out_valid in cycle k+M+1 (inference) or k+2M+2 (learn pass).
// Backpressure: ready is high only in IDLE; valid while busy is ignored, nothing is queued.
//
// Ports: clock/reset_n (async active-low); valid/ready/learn/in/expected_out sampled at accept;
//        out/out_valid/expected_in results; weights live registers; activation_max/min running stats.
// Optional: define NEURON_LAYER_STATS_EN for per-neuron running max/min pre-activation
//           (otherwise activation_max/min are tied to 0).
module neuron_learn_layer_seq
  import neuron_learn_layer_seq_pkg::*;
#(
  parameter int N        = 16,
  parameter int M        = 49,
  parameter int LR_SHIFT = 4,
  parameter int W_INIT   = 0
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        valid,
  output logic                        ready,
  input  logic                        learn,
  input  logic [N-1:0][ZW-1:0]        in,
  input  logic [M-1:0][ZW-1:0]        expected_out,
  output logic [M-1:0][ZW-1:0]        out,
  output logic                        out_valid,
  output logic [N-1:0][ZW-1:0]        expected_in,
  output logic [M-1:0][N-1:0][FW-1:0] weights,
  output logic [M-1:0][FW-1:0]        activation_max,
  output logic [M-1:0][FW-1:0]        activation_min
);

  localparam int JW   = (M > 1) ? $clog2(M) : 1;
  localparam int ACCW = ZW + ((M > 1) ? $clog2(M) : 0);

  typedef logic [JW-1:0] idx_t;
  localparam idx_t J_LAST = idx_t'(M - 1);

  layer_state_e                state_q, state_d;
  idx_t                        j_q, j_d;
  logic [N-1:0][ZW-1:0]        in_q, in_d;
  logic [M-1:0][ZW-1:0]        exp_q, exp_d;
  logic                        learn_q, learn_d;
  logic [M-1:0][ZW-1:0]        out_q, out_d;
  logic                        out_valid_q, out_valid_d;
  logic [N-1:0][ZW-1:0]        exp_in_q, exp_in_d;
  logic [M-1:0][N-1:0][FW-1:0] w_q, w_d;
  logic [N-1:0][ACCW-1:0]      acc_q, acc_d;

  frac_t              act;
  logic signed [ZW:0] err;
  wide_t              err_w;

  neuron_mac_row #(.N(N)) u_mac (
    .w (w_q[j_q]),
    .x (in_q),
    .a (act)
  );

  // Error of the neuron currently being trained, using the out value from this sample's FWD pass.
  assign err   = signed'({1'b0, exp_q[j_q]}) - signed'({1'b0, out_q[j_q]});
  assign err_w = wide_t'(err);

  always_comb begin
    state_d     = state_q;
    j_d         = j_q;
    in_d        = in_q;
    exp_d       = exp_q;
    learn_d     = learn_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    exp_in_d    = exp_in_q;
    w_d         = w_q;
    acc_d       = acc_q;

    case (state_q)
      IDLE: begin
        if (valid) begin
          in_d    = in;
          exp_d   = expected_out;
          learn_d = learn;
          acc_d   = '0;
          j_d     = '0;
          state_d = FWD;
        end
      end
      FWD: begin
        out_d[j_q] = to_zero2one(act);
        if (j_q == J_LAST) begin
          j_d     = '0;
          state_d = learn_q ? LRN : DONE;
        end else begin
          j_d = j_q + idx_t'(1);
        end
      end
      LRN: begin
        for (int i = 0; i < N; i++) begin
          w_d[j_q][i] = sat_frac(to_wide_f(frac_t'(w_q[j_q][i]))
                        + ((err_w * to_wide_z(in_q[i])) >>> (ZERO2ONE_FRAC + LR_SHIFT)));
          // Back-propagated target uses the weight as it was before this update.
          acc_d[i] = acc_q[i] + ACCW'(back_target(in_q[i], err_w, frac_t'(w_q[j_q][i])));
        end
        if (j_q == J_LAST) begin
          j_d     = '0;
          state_d = AVG;
        end else begin
          j_d = j_q + idx_t'(1);
        end
      end
      AVG: begin
        for (int i = 0; i < N; i++) begin
          exp_in_d[i] = ZW'(acc_q[i] / ACCW'(M));
        end
        state_d = DONE;
      end
      DONE: begin
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      j_q         <= '0;
      in_q        <= '0;
      exp_q       <= '0;
      learn_q     <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      exp_in_q    <= '0;
      acc_q       <= '0;
      for (int j = 0; j < M; j++) begin
        for (int i = 0; i < N; i++) begin
          w_q[j][i] <= (((i + j) % 2) == 0) ? frac_t'(W_INIT) : frac_t'(-W_INIT);
        end
      end
    end else begin
      state_q     <= state_d;
      j_q         <= j_d;
      in_q        <= in_d;
      exp_q       <= exp_d;
      learn_q     <= learn_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      exp_in_q    <= exp_in_d;
      acc_q       <= acc_d;
      w_q         <= w_d;
    end
  end

`ifdef NEURON_LAYER_STATS_EN
  logic [M-1:0][FW-1:0] act_max_q, act_max_d, act_min_q, act_min_d;

  always_comb begin
    act_max_d = act_max_q;
    act_min_d = act_min_q;
    if (state_q == FWD) begin
      if (act > frac_t'(act_max_q[j_q])) act_max_d[j_q] = act;
      if (act < frac_t'(act_min_q[j_q])) act_min_d[j_q] = act;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j < M; j++) begin
        act_max_q[j] <= FRAC_MIN;
        act_min_q[j] <= FRAC_MAX;
      end
    end else begin
      act_max_q <= act_max_d;
      act_min_q <= act_min_d;
    end
  end

  assign activation_max = act_max_q;
  assign activation_min = act_min_q;
`else
  assign activation_max = '0;
  assign activation_min = '0;
`endif

  assign ready       = (state_q == IDLE);
  assign out         = out_q;
  assign out_valid   = out_valid_q;
  assign expected_in = exp_in_q;
  assign weights     = w_q;

endmodule
